btog_counter: RTL and testbench
===============================

// Module: btog_counter
// PURPOSE
//   Binary-to-gray encoder with an integrated up/down binary counter and a one-entry registered output.
//   Produces a stream of gray codes in which adjacent codes differ by one bit, for use as a code source
//   (e.g. pointers, position codes) that pairs with the team's gray-to-binary decoding path.
//   The output uses a valid/ready handshake. The counter advances only when the output slot can accept a code.
// PARAMETERS
//   WIDTH  4  code width in bits (>= 2); all ports and arithmetic are WIDTH bits, modulo 2**WIDTH
// PORTS
//   clk        in   1      single clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   load       in   1      load load_bin into counter and output (priority over en)
//   load_bin   in   WIDTH  binary value to load
//   en         in   1      request one count step
//   up         in   1      step direction: 1 = +1, 0 = -1 (sampled with en)
//   out_ready  in   1      consumer accepts current gray/bin when out_valid=1
//   out_valid  out  1      gray/bin hold a code not yet accepted
//   gray       out  WIDTH  registered gray code = bin ^ (bin >> 1)
//   bin        out  WIDTH  registered binary value matching gray
//   wrap       out  1      high with a code produced by a step that crossed max->0 (up) or 0->max (down)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): cnt=0, gray=0, bin=0, out_valid=0, wrap=0. Overrides load and en.
//     A reset mid-stream discards any pending code.
//   - slot_free = !out_valid || out_ready.
//   - FSM states:
//     - EMPTY (out_valid=0): the output slot is free.
//     - FULL (out_valid=1): a code is waiting.
//     - The state register is out_valid itself.
//   - Load (load=1, rst=0):
//     - Taken every cycle, regardless of slot_free.
//     - cnt<=load_bin, bin<=load_bin, gray<=enc(load_bin), out_valid<=1, wrap<=0.
//     - A pending unaccepted code is overwritten. en is ignored that cycle.
//   - Step (en=1, load=0, slot_free=1):
//     - nxt = up ? cnt+1 : cnt-1 (mod 2**WIDTH).
//     - cnt<=nxt, bin<=nxt, gray<=nxt^(nxt>>1), out_valid<=1.
//     - wrap<=(up && cnt=={WIDTH{1'b1}}) || (!up && cnt==0).
//   - Stall (en=1, load=0, slot_free=0): cnt, gray, bin, wrap and out_valid all hold. The step is not queued;
//     en must stay high until the step is taken.
//   - Drain (out_valid=1, out_ready=1, no load or step that cycle): out_valid<=0. gray, bin and wrap hold their values.
//   - Accept and step in the same cycle: the old code is consumed and the new code is presented next cycle.
//     out_valid stays 1, giving 1 code/cycle throughput.
//   - Latency: 1 cycle from a taken load/step to out_valid=1 with the new code.
//   - First step after reset emits bin=1, gray=0...01. The code 0 is emitted only via load or wrap.
//   - gray is always enc(bin). gray and bin change only on load, step or reset.
// TESTING (WIDTH=4)
//   1. Reset:
//      - Stimulus: rst=1 for 2 cycles with en=1, load=1.
//      - Required: gray=0, bin=0, out_valid=0, wrap=0. After rst=0 with idle inputs, all outputs hold.
//   2. Up sweep:
//      - Stimulus: load 0, then en=1, up=1, out_ready=1 for 16 cycles.
//      - Required: gray=0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000, then 0000 with wrap=1.
//        Each adjacent pair differs by exactly 1 bit.
//   3. Down wrap:
//      - Stimulus: load 4'd2, up=0, en=1, out_ready=1.
//      - Required: gray 0011, 0001, 0000, then 1000 (bin=15) with wrap=1 only on that code.
//   4. Backpressure:
//      - Stimulus: mid-sweep at bin=5 (gray 0111), hold out_ready=0 for 4 cycles with en=1.
//      - Required: gray=0111 and out_valid=1 held. On release the next codes are 0101 then 0100, with none skipped.
//   5. Load over pending code:
//      - Stimulus: with out_valid=1 and out_ready=0, assert load=1, load_bin=4'd9, en=1.
//      - Required: next cycle bin=1001, gray=1101, wrap=0, out_valid=1.
//   6. Reset mid-run:
//      - Stimulus: pulse rst during the up sweep at bin=11.
//      - Required: next cycle all outputs are 0. Resuming en=1 emits bin=1, gray=0001.

Source files
------------

// File: rtl/btog_counter.sv
// ----------------------------------------------------------------------------
// btog_counter
//   Up/down binary counter whose every new value is presented as a registered
//   gray code (plus the matching binary value) in a one-entry output slot.
//   Adjacent codes in a step sequence differ by exactly one bit. This makes the
//   block suitable as a pointer or position source for a gray-to-binary
//   decoding path.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset (overrides load/en)
//   load       in   1      load load_bin into counter and output slot
//   load_bin   in   WIDTH  binary value to load
//   en         in   1      request one count step
//   up         in   1      step direction, 1 = +1, 0 = -1
//   out_ready  in   1      consumer accepts the current code
//   out_valid  out  1      slot holds a code not yet accepted
//   gray       out  WIDTH  registered gray code, always bin ^ (bin >> 1)
//   bin        out  WIDTH  registered binary value of the presented code
//   wrap       out  1      code came from a step crossing max->0 or 0->max
//
// Handshake: a code transfers on a rising edge where out_valid=1 and
// out_ready=1. out_valid never drops without a transfer unless reset occurs.
// A load replaces a pending code. While out_valid=1 and out_ready=0, the
// presented gray/bin/wrap stay stable.
// ----------------------------------------------------------------------------
module btog_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic             en,
   input  logic             up,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             wrap
);

   // The output slot occupancy is the whole FSM. out_valid is the state.
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   logic             w_slot_free;
   logic             w_take_step;
   logic             w_update;
   logic [WIDTH-1:0] w_step_bin;
   logic [WIDTH-1:0] w_new_bin;
   logic             w_step_wrap;

   assign w_slot_free = (r_state == S_EMPTY) || out_ready;
   // A step that finds the slot busy is dropped. The requester keeps en high.
   assign w_take_step = en && !load && w_slot_free;
   assign w_update    = load || w_take_step;

   assign w_step_bin  = up ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
   assign w_step_wrap = up ? (r_cnt == {WIDTH{1'b1}}) : (r_cnt == '0);
   assign w_new_bin   = load ? load_bin : w_step_bin;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (w_update) begin
         w_state_nxt = S_FULL;
      end else if ((r_state == S_FULL) && out_ready) begin
         w_state_nxt = S_EMPTY;
      end
   end

   // Output logic
   always_comb begin
      out_valid = (r_state == S_FULL);
   end

   // Counter and code registers. The counter value is also the presented
   // binary code, because both update together on every load or step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
      end else if (w_update) begin
         r_cnt  <= w_new_bin;
         r_gray <= w_new_bin ^ (w_new_bin >> 1);
         r_wrap <= load ? 1'b0 : w_step_wrap;
      end
   end

   assign bin  = r_cnt;
   assign gray = r_gray;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_btog_counter.sv
// ----------------------------------------------------------------------------
// tb_btog_counter
//   Directed bench for btog_counter with WIDTH=4. Stimulus tasks push each
//   code that the consumer will accept onto exp_q. A negedge monitor pops and
//   compares the queue on every accepted transfer. Stall, overwrite and reset
//   states are also checked directly after the edge.
// ----------------------------------------------------------------------------
module tb_btog_counter;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] load_bin;
   logic         en;
   logic         up;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] gray;
   logic [W-1:0] bin;
   logic         wrap;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected accepted code: {gray, bin, wrap}
   logic [2*W:0] exp_q[$];

   // Hand-written reflected gray codes for bin = 0..15
   logic [W-1:0] gray_tab [16] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
   };

   btog_counter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_bin  (load_bin),
      .en        (en),
      .up        (up),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .gray      (gray),
      .bin       (bin),
      .wrap      (wrap)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W:0] code(input int b, input logic w);
      logic [W-1:0] bb;
      bb = W'(b);
      return {gray_tab[bb], bb, w};
   endfunction

   // ---------------- driver tasks ----------------
   // Apply inputs for one rising edge, then return 1 time unit after it.
   task automatic drive(input logic l, input logic [W-1:0] lb, input logic e,
                        input logic u, input logic r);
      rst       = 1'b0;
      load      = l;
      load_bin  = lb;
      en        = e;
      up        = u;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      load      = 1'b1;
      load_bin  = 4'hA;
      en        = 1'b1;
      up        = 1'b1;
      out_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_outputs(input string name, input logic v, input int b, input logic w);
      logic [W-1:0] bb;
      bb = W'(b);
      check({name, "_valid"}, 32'(out_valid), 32'(v));
      check({name, "_bin"},   32'(bin),       32'(bb));
      check({name, "_gray"},  32'(gray),      32'(gray_tab[bb]));
      check({name, "_wrap"},  32'(wrap),      32'(w));
   endtask

   // Consume the pending code and confirm the slot empties with data held.
   task automatic drain(input string name, input int b, input logic w);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check_outputs(name, 1'b0, b, w);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_unexpected: got gray=%b bin=%0d wrap=%b with nothing expected",
                     gray, bin, wrap);
         end else begin
            check("accept", 32'({gray, bin, wrap}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; load = 1'b0; load_bin = '0; en = 1'b0; up = 1'b0; out_ready = 1'b0;

      // 1. Reset overrides load and en, and outputs hold when idle.
      do_reset(2);
      check_outputs("reset", 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
         check_outputs("idle", 1'b0, 0, 1'b0);
      end

      // 2. Up sweep from 0 through wrap.
      drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
      exp_q.push_back(code(0, 1'b0));
      check_outputs("load0", 1'b1, 0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
         exp_q.push_back(code(i % 16, i == 16));
      end
      check_outputs("up_wrap", 1'b1, 0, 1'b1);
      drain("drain_up", 0, 1'b1);

      // 3. Down sweep through 0 -> 15.
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(code(2, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1); exp_q.push_back(code(1, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1); exp_q.push_back(code(0, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1); exp_q.push_back(code(15, 1'b1));
      check_outputs("down_wrap", 1'b1, 15, 1'b1);
      drain("drain_down", 15, 1'b1);

      // 4. Backpressure at bin=5.
      drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b1); exp_q.push_back(code(3, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(4, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(5, 1'b0));
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
         check_outputs("stall", 1'b1, 5, 1'b0);
      end
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(6, 1'b0));
      check_outputs("release1", 1'b1, 6, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(7, 1'b0));
      check_outputs("release2", 1'b1, 7, 1'b0);
      drain("drain_bp", 7, 1'b0);

      // 5. Load overwrites a pending wrapped code.
      drive(1'b1, 4'd15, 1'b0, 1'b1, 1'b1); exp_q.push_back(code(15, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);    // accepts 15; code 0 stays pending
      check_outputs("pending", 1'b1, 0, 1'b1);
      drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b0);  exp_q.push_back(code(9, 1'b0));
      check_outputs("load_over", 1'b1, 9, 1'b0);
      check("load_over_gray_lit", 32'(gray), 32'(4'b1101));
      drain("drain_load", 9, 1'b0);

      // 6. Reset mid-run at bin=11 discards the pending code.
      drive(1'b1, 4'd8, 1'b0, 1'b1, 1'b1); exp_q.push_back(code(8, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(9, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(10, 1'b0));
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   // code 11 is discarded by reset
      check_outputs("pre_rst", 1'b1, 11, 1'b0);
      do_reset(1);
      check_outputs("mid_rst", 1'b0, 0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);   exp_q.push_back(code(1, 1'b0));
      check_outputs("post_rst", 1'b1, 1, 1'b0);
      check("post_rst_gray_lit", 32'(gray), 32'(4'b0001));
      drain("drain_end", 1, 1'b0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
